controller_sequencer: RTL and testbench

//  SAP-1 controller/sequencer. 6-state one-hot ring counter (T1..T6) plus opcode decode.

---
 rtl/controller_sequencer.sv | 76 +++++++
 tb/tb_controller_sequencer.sv | 104 ++++++++++
 2 files changed

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 one-hot T1..T6 ring plus opcode decode that drives the 12-bit control word
module controller_sequencer #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_OUT = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input  logic       CLK,
   input  logic       CLR_bar,
   input  logic       RUN,
   input  logic [3:0] opcode,
   output logic [5:0] t_state,
   output logic       HLT,
   output logic       Cp,
   output logic       Ep,
   output logic       Lm_bar,
   output logic       CE_bar,
   output logic       Li_bar,
   output logic       Ei_bar,
   output logic       La_bar,
   output logic       Ea,
   output logic       Su,
   output logic       Eu,
   output logic       Lb_bar,
   output logic       Lo_bar
);
   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } state_t;
   state_t state, state_nxt;
   logic halted, halted_nxt;
   logic [5:0] t;
   logic lda, alu, sub, out, mem;
   always_ff @(posedge CLK)
      if (!CLR_bar) begin
         state  <= T1;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         halted <= halted_nxt;
      end
   always_comb begin
      state_nxt  = state;
      halted_nxt = halted;
      if (RUN && !halted) begin
         if (state == T4 && opcode == OP_HLT) halted_nxt = 1'b1;
         else state_nxt = state_t'({state[4:0], state[5]});
      end
      t       = halted ? 6'b0 : state;
      lda     = opcode == OP_LDA;
      sub     = opcode == OP_SUB;
      alu     = opcode == OP_ADD || sub;
      out     = opcode == OP_OUT;
      mem     = lda || alu;
      t_state = state;
      HLT     = halted;
      Ep      = t[0];
      Cp      = t[1];
      Lm_bar  = ~(t[0] | (t[3] & mem));
      CE_bar  = ~(t[2] | (t[4] & mem));
      Li_bar  = ~t[2];
      Ei_bar  = ~(t[3] & mem);
      La_bar  = ~((t[4] & lda) | (t[5] & alu));
      Ea      = t[3] & out;
      Su      = t[5] & sub;
      Eu      = t[5] & alu;
      Lb_bar  = ~(t[4] & alu);
      Lo_bar  = ~(t[3] & out);
   end
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: scoreboard bench comparing ring state, HLT and control word after every clock
module tb_controller_sequencer;
   logic       CLK = 1'b0;
   logic       CLR_bar = 1'b0;
   logic       RUN = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic [5:0] t_state;
   logic       HLT, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar;
   controller_sequencer dut (
      .CLK(CLK), .CLR_bar(CLR_bar), .RUN(RUN), .opcode(opcode),
      .t_state(t_state), .HLT(HLT), .Cp(Cp), .Ep(Ep), .Lm_bar(Lm_bar), .CE_bar(CE_bar),
      .Li_bar(Li_bar), .Ei_bar(Ei_bar), .La_bar(La_bar), .Ea(Ea), .Su(Su), .Eu(Eu),
      .Lb_bar(Lb_bar), .Lo_bar(Lo_bar)
   );
   always #5 CLK = ~CLK;
   localparam int CP = 11, EP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
   localparam int LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;
   localparam logic [11:0] IDLE = 12'h3E3;
   typedef struct {
      logic [5:0]  ts;
      logic        h;
      logic [11:0] cw;
   } exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int mt = 0;
   bit mh = 1'b0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [11:0] exp_cw(input int st, input logic [3:0] op, input bit h);
      logic [11:0] w;
      w = IDLE;
      if (h) return w;
      case (st)
         0: begin w[EP] = 1'b1; w[LM] = 1'b0; end
         1: w[CP] = 1'b1;
         2: begin w[CE] = 1'b0; w[LI] = 1'b0; end
         3: if (op inside {4'h0, 4'h1, 4'h2}) begin w[EI] = 1'b0; w[LM] = 1'b0; end
            else if (op == 4'hE) begin w[EA] = 1'b1; w[LO] = 1'b0; end
         4: if (op == 4'h0) begin w[CE] = 1'b0; w[LA] = 1'b0; end
            else if (op inside {4'h1, 4'h2}) begin w[CE] = 1'b0; w[LB] = 1'b0; end
         5: if (op inside {4'h1, 4'h2}) begin w[EU] = 1'b1; w[LA] = 1'b0; w[SU] = op == 4'h2; end
         default: ;
      endcase
      return w;
   endfunction
   task automatic step(input bit run, input bit clr, input logic [3:0] op);
      exp_t e, g;
      int bus;
      @(negedge CLK);
      RUN = run;
      CLR_bar = clr;
      opcode = op;
      @(posedge CLK);
      if (!clr) begin
         mt = 0;
         mh = 1'b0;
      end else if (run && !mh) begin
         if (mt == 3 && op == 4'hF) mh = 1'b1;
         else mt = (mt + 1) % 6;
      end
      e.ts = 6'(1 << mt);
      e.h  = mh;
      e.cw = exp_cw(mt, op, mh);
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      g = sb.pop_front();
      check("t_state", {26'd0, t_state}, {26'd0, g.ts});
      check("hlt", {31'd0, HLT}, {31'd0, g.h});
      check("cw", {20'd0, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar},
            {20'd0, g.cw});
      bus = int'(Ep) + int'(Eu) + int'(Ea) + int'(!CE_bar) + int'(!Ei_bar);
      check("bus_excl", {31'd0, bus <= 1}, 32'd1);
   endtask
   initial begin
      step(1, 0, 4'h0);
      for (int i = 0; i < 6; i++) step(1, 1, 4'h0);
      for (int i = 0; i < 6; i++) step(1, 1, 4'h1);
      for (int i = 0; i < 6; i++) step(1, 1, 4'h2);
      for (int i = 0; i < 6; i++) step(1, 1, 4'hE);
      for (int i = 0; i < 6; i++) step(1, 1, 4'h7);
      for (int i = 0; i < 14; i++) step(1, 1, 4'hF);
      step(1, 0, 4'hF);
      for (int i = 0; i < 2; i++) step(1, 1, 4'h0);
      for (int i = 0; i < 3; i++) step(0, 1, 4'h0);
      step(1, 1, 4'h0);
      step(1, 1, 4'h0);
      step(1, 0, 4'h0);
      for (int i = 0; i < 60; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, 4'($urandom_range(0, 15)));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
